// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter owner for the single-cycle core.
// Chooses the next PC (sequential / branch / jump), gates execution through
// `commit`, and tracks RUN / STEP_WAIT / HALTED / TRAP modes plus the retire count.
// Optional feature macro: PC_SEQ_STEP_EN enables single-step mode, which
// synchronizes and edge-detects the step button.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run_mode,
  input  logic        step_in,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        halt_req,
  input  logic        resume,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        commit,
  output logic        halted,
  output logic        trap,
  output logic [31:0] trap_addr,
  output logic [31:0] instret,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    S_RUN       = 2'b00,
    S_STEP_WAIT = 2'b01,
    S_HALTED    = 2'b10,
    S_TRAP      = 2'b11
  } state_e;

  // Byte span of legal instruction memory and the last legal word address.
  localparam logic [31:0] SPAN    = 32'(4 * IMEM_WORDS);
  localparam logic [31:0] LAST_PC = RESET_PC + SPAN - 32'd4;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instret_q, instret_d;
  logic [31:0] trap_addr_q, trap_addr_d;

  logic        step_pulse;
  state_e      mode_state;   // where the core goes when it is free to execute

`ifdef PC_SEQ_STEP_EN
  logic sync1_q, sync2_q, prev_q;

  // Two-flop synchronizer for the raw button, plus a delayed copy for edge detect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= step_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // One pulse per press, no matter how long the button is held.
  assign step_pulse = sync2_q & ~prev_q;
  assign mode_state = run_mode ? S_RUN : S_STEP_WAIT;
`else
  // Without step support the mode and button inputs have no effect.
  logic unused_step_inputs;
  assign unused_step_inputs = run_mode ^ step_in;
  assign step_pulse = 1'b0;
  assign mode_state = S_RUN;
`endif

  logic [31:0] seq_pc;
  logic [31:0] target;
  logic        redirect;
  logic        bad_target;
  logic [31:0] target_off;

  // Sequential successor with wrap at the top of imem; redirect target and its legality.
  always_comb begin
    seq_pc     = (pc_q == LAST_PC) ? RESET_PC : pc_q + 32'd4;
    redirect   = jump | branch_taken;
    target     = jump ? jump_target : branch_target;
    target_off = target - RESET_PC;
    bad_target = (target[1:0] != 2'b00) || (target_off >= SPAN);
  end

  // Next-state, next-PC, commit gating and retire accounting.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instret_d   = instret_q;
    trap_addr_d = trap_addr_q;
    commit      = 1'b0;

    case (state_q)
      S_RUN:       commit = 1'b1;
      S_STEP_WAIT: begin
        // Switching back to RUN takes a cycle in which nothing executes.
        commit = step_pulse & ~run_mode;
        if (run_mode) state_d = S_RUN;
      end
      S_HALTED: begin
        if (resume) begin
          pc_d    = seq_pc;
          state_d = mode_state;
        end
      end
      S_TRAP:  ;
      default: ;
    endcase

    if (commit) begin
      instret_d = instret_q + 32'd1;
      if (halt_req) begin
        state_d = S_HALTED;
      end else if (redirect && bad_target) begin
        state_d     = S_TRAP;
        trap_addr_d = target;
      end else begin
        pc_d    = redirect ? target : seq_pc;
        state_d = mode_state;
      end
    end
  end

  // Architectural state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      pc_q        <= RESET_PC;
      instret_q   <= 32'd0;
      trap_addr_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instret_q   <= instret_d;
      trap_addr_q <= trap_addr_d;
    end
  end

  assign pc        = pc_q;
  assign pc_plus4  = pc_q + 32'd4;
  assign halted    = (state_q == S_HALTED);
  assign trap      = (state_q == S_TRAP);
  assign trap_addr = trap_addr_q;
  assign instret   = instret_q;
  assign state     = state_q;

endmodule
